// File: rtl/hash_table_pkg.sv
// Shared hash-table parameters used by the data-table support blocks.
package hash_table;

  // Address width of the hash-table data table (depth = 2**TABLE_ADDR_WIDTH).
  localparam int TABLE_ADDR_WIDTH = 8;

endpackage

// File: rtl/empty_ptr_ram.sv
// Simple dual-port pointer RAM: one write port, one read port with a
// registered (1-cycle) read. The read register only updates when rd_en_i
// is high, so the output holds its last fetched value otherwise.
module empty_ptr_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; contents are deliberately not reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Registered read port; only the output register is cleared on reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_data_o <= '0;
    end else if (rd_en_i) begin
      rd_data_o <= mem[rd_addr_i];
    end
  end

endmodule

// File: rtl/empty_ptr_storage.sv
// Free-address pool for the hash-table data table.
//
// After reset the pool fills itself with every address 0..D-1, then offers
// them to the insert stage in FIFO order. The delete stage returns freed
// addresses through add_empty_ptr_i.
//
// Handshake: next_empty_ptr_o is a show-ahead value qualified by
// next_empty_ptr_val_o. A transfer happens in any cycle where both
// next_empty_ptr_val_o and next_empty_ptr_rd_ack_i are high; the pointer is
// then popped and val drops for exactly one cycle while the next entry is
// read from the RAM. An ack with val low is not a transfer and sets the
// sticky underflow_o. add_empty_ptr_en_i is an unconditional strobe (no
// back-pressure); adds that cannot be stored set the sticky overflow_o.
module empty_ptr_storage
  import hash_table::*;
#(
  parameter int A_WIDTH = TABLE_ADDR_WIDTH
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [A_WIDTH-1:0] add_empty_ptr_i,
  input  logic               add_empty_ptr_en_i,
  output logic [A_WIDTH-1:0] next_empty_ptr_o,
  output logic               next_empty_ptr_val_o,
  input  logic               next_empty_ptr_rd_ack_i,
  output logic [A_WIDTH:0]   empty_cnt_o,
  output logic               init_done_o,
  output logic               overflow_o,
  output logic               underflow_o,
  output logic [1:0]         state_o
);

  localparam int D = 2 ** A_WIDTH;
  localparam logic [A_WIDTH:0]   FULL_CNT = (A_WIDTH + 1)'(D);
  localparam logic [A_WIDTH-1:0] LAST_IDX = A_WIDTH'(D - 1);

  typedef enum logic [1:0] {
    INIT_S     = 2'd0,
    PREFETCH_S = 2'd1,
    WORK_S     = 2'd2
  } state_t;

  state_t             state_q;
  logic [A_WIDTH-1:0] wr_ptr_q;
  logic [A_WIDTH-1:0] rd_ptr_q;
  logic [A_WIDTH-1:0] init_cnt_q;
  logic [A_WIDTH:0]   cnt_q;
  logic               val_q;
  logic               init_done_q;
  logic               overflow_q;
  logic               underflow_q;

  logic               in_work;
  logic               full;
  logic               ack_ok;
  logic               add_ok;
  logic               fetch;
  logic               ram_wr_en;
  logic [A_WIDTH-1:0] ram_wr_addr;
  logic [A_WIDTH-1:0] ram_wr_data;

  // Transfer qualification and RAM port steering.
  always_comb begin
    in_work     = (state_q == WORK_S);
    full        = (cnt_q == FULL_CNT);
    ack_ok      = next_empty_ptr_rd_ack_i && val_q;
    add_ok      = add_empty_ptr_en_i && in_work && !full;
    // Fetch the head entry whenever nothing is presented but entries exist.
    // With cnt_q >= 1 the head (rd_ptr) never equals the write slot (wr_ptr)
    // unless full, and adds are refused when full, so no read/write aliasing.
    fetch       = (state_q == PREFETCH_S) || (in_work && !val_q && (cnt_q != '0));
    ram_wr_en   = (state_q == INIT_S) || add_ok;
    ram_wr_addr = (state_q == INIT_S) ? init_cnt_q : wr_ptr_q;
    ram_wr_data = (state_q == INIT_S) ? init_cnt_q : add_empty_ptr_i;
  end

  empty_ptr_ram #(
    .WIDTH (A_WIDTH),
    .DEPTH (D),
    .AW    (A_WIDTH)
  ) u_ram (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (ram_wr_en),
    .wr_addr_i (ram_wr_addr),
    .wr_data_i (ram_wr_data),
    .rd_en_i   (fetch),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (next_empty_ptr_o)
  );

  // Control FSM: initial fill, first prefetch, then pop/push bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= INIT_S;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      init_cnt_q  <= '0;
      cnt_q       <= '0;
      val_q       <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      case (state_q)
        INIT_S: begin
          init_cnt_q <= init_cnt_q + 1'b1;
          if (init_cnt_q == LAST_IDX) begin
            cnt_q   <= FULL_CNT;
            state_q <= PREFETCH_S;
          end
        end
        PREFETCH_S: begin
          // The RAM read issued this cycle lands on the output at this edge.
          val_q       <= 1'b1;
          init_done_q <= 1'b1;
          state_q     <= WORK_S;
        end
        WORK_S: begin
          case ({add_ok, ack_ok})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
          endcase
          if (add_ok) begin
            wr_ptr_q <= wr_ptr_q + 1'b1;
          end
          if (ack_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
            val_q    <= 1'b0;
          end else if (fetch) begin
            val_q <= 1'b1;
          end
        end
        default: begin
          state_q <= INIT_S;
        end
      endcase
    end
  end

  // Sticky error flags for refused adds and acks without a valid pointer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (add_empty_ptr_en_i && !add_ok) begin
        overflow_q <= 1'b1;
      end
      if (next_empty_ptr_rd_ack_i && !val_q) begin
        underflow_q <= 1'b1;
      end
    end
  end

  assign next_empty_ptr_val_o = val_q;
  assign empty_cnt_o          = cnt_q;
  assign init_done_o          = init_done_q;
  assign overflow_o           = overflow_q;
  assign underflow_o          = underflow_q;
  assign state_o              = state_q;

endmodule

// File: tb/tb_empty_ptr_storage.sv
// Bench for empty_ptr_storage with A_WIDTH=3: directed scenarios plus a
// randomized add/ack phase, all compared against a queue-based model.
module tb_empty_ptr_storage;

  localparam int AW = 3;
  localparam int D  = 2 ** AW;

  logic          clk;
  logic          rst;
  logic [AW-1:0] add_ptr;
  logic          add_en;
  logic [AW-1:0] next_ptr;
  logic          next_val;
  logic          rd_ack;
  logic [AW:0]   empty_cnt;
  logic          init_done;
  logic          overflow;
  logic          underflow;
  logic [1:0]    state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the FIFO of free addresses, whether its head is
  // currently presented, and the sticky flags.
  int m_q[$];
  bit m_pres;
  bit m_done;
  bit m_ovf;
  bit m_unf;
  int m_edges;

  empty_ptr_storage #(.A_WIDTH(AW)) dut (
    .clk_i                   (clk),
    .rst_i                   (rst),
    .add_empty_ptr_i         (add_ptr),
    .add_empty_ptr_en_i      (add_en),
    .next_empty_ptr_o        (next_ptr),
    .next_empty_ptr_val_o    (next_val),
    .next_empty_ptr_rd_ack_i (rd_ack),
    .empty_cnt_o             (empty_cnt),
    .init_done_o             (init_done),
    .overflow_o              (overflow),
    .underflow_o             (underflow),
    .state_o                 (state_dbg)
  );

  // Clock and reset defaults.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_q.delete();
    m_pres  = 1'b0;
    m_done  = 1'b0;
    m_ovf   = 1'b0;
    m_unf   = 1'b0;
    m_edges = 0;
  endfunction

  // One clock edge of the model, given the inputs sampled at that edge.
  function automatic void model_step(input bit add, input int a, input bit ack);
    int cnt;
    bit ack_ok;
    bit add_ok;
    bit fetch;
    cnt    = m_q.size();
    ack_ok = ack && m_pres;
    add_ok = add && m_done && (cnt < D);
    fetch  = m_done && !m_pres && (cnt != 0);
    if (ack && !m_pres) m_unf = 1'b1;
    if (add && !add_ok) m_ovf = 1'b1;
    if (!m_done) begin
      m_edges++;
      if (m_edges == D) begin
        for (int k = 0; k < D; k++) m_q.push_back(k);
      end
      if (m_edges == D + 1) begin
        m_done = 1'b1;
        m_pres = 1'b1;
      end
      return;
    end
    if (ack_ok) begin
      void'(m_q.pop_front());
      m_pres = 1'b0;
    end else if (fetch) begin
      m_pres = 1'b1;
    end
    if (add_ok) m_q.push_back(a);
  endfunction

  function automatic bit in_pool(input int v);
    foreach (m_q[i]) if (m_q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Compare all outputs against the model (called at a negedge).
  task automatic check_outputs();
    check_val("val", 32'(next_val), 32'(m_pres));
    if (m_pres) check_val("ptr", 32'(next_ptr), 32'(m_q[0]));
    check_val("cnt", 32'(empty_cnt), 32'(m_q.size()));
    check_val("init_done", 32'(init_done), 32'(m_done));
    check_val("overflow", 32'(overflow), 32'(m_ovf));
    check_val("underflow", 32'(underflow), 32'(m_unf));
  endtask

  // Driver: starts and ends at a negedge; checks, drives, advances one edge.
  task automatic step(input bit add, input int a, input bit ack);
    check_outputs();
    add_en  = add;
    add_ptr = AW'(a);
    rd_ack  = ack;
    @(posedge clk);
    model_step(add, a, ack);
    @(negedge clk);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_ptr"}, 32'(next_ptr), 0);
    check_val({tag, "_val"}, 32'(next_val), 0);
    check_val({tag, "_cnt"}, 32'(empty_cnt), 0);
    check_val({tag, "_done"}, 32'(init_done), 0);
    check_val({tag, "_ovf"}, 32'(overflow), 0);
    check_val({tag, "_unf"}, 32'(underflow), 0);
  endtask

  // Asynchronous reset pulse; returns at the negedge where reset drops.
  task automatic do_reset(input string tag);
    rst    = 1'b1;
    add_en = 1'b0;
    rd_ack = 1'b0;
    #1;
    model_reset();
    check_reset_values(tag);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Ack every presented pointer until empty; checks the order 0..D-1.
  task automatic drain_in_order(input string tag);
    int got_n;
    got_n = 0;
    for (int c = 0; c < 4 * D && (m_q.size() != 0 || m_pres); c++) begin
      if (m_pres) begin
        check_val({tag, "_order"}, 32'(next_ptr), 32'(got_n));
        got_n++;
      end
      step(1'b0, 0, m_pres);
    end
    check_val({tag, "_drained"}, 32'(got_n), 32'(D));
  endtask

  initial begin
    rst     = 1'b1;
    add_en  = 1'b0;
    add_ptr = '0;
    rd_ack  = 1'b0;
    model_reset();
    @(negedge clk);
    do_reset("rst0");

    // Initial fill: D fill cycles plus one prefetch.
    for (int c = 0; c < D + 1; c++) step(1'b0, 0, 1'b0);
    check_val("init_done_lat", 32'(init_done), 1);
    check_val("init_cnt", 32'(empty_cnt), 32'(D));
    check_val("init_ptr", 32'(next_ptr), 0);
    check_val("init_val", 32'(next_val), 1);

    // Add while full is dropped and flagged.
    step(1'b1, 2, 1'b0);
    check_val("full_ovf", 32'(overflow), 1);
    check_val("full_cnt", 32'(empty_cnt), 32'(D));

    drain_in_order("init");
    for (int c = 0; c < 3; c++) step(1'b0, 0, 1'b0);
    check_val("empty_unf", 32'(underflow), 0);

    // Add to empty storage: presented two cycles after the strobe.
    step(1'b1, 5, 1'b0);
    step(1'b0, 0, 1'b0);
    check_val("add_empty_val", 32'(next_val), 1);
    check_val("add_empty_ptr", 32'(next_ptr), 5);
    check_val("add_empty_cnt", 32'(empty_cnt), 1);
    step(1'b0, 0, 1'b1);
    step(1'b0, 0, 1'b1);
    check_val("late_ack_unf", 32'(underflow), 1);

    // Randomized add/ack traffic with legal (unique) returned addresses.
    do_reset("rst1");
    for (int c = 0; c < D + 1; c++) step(1'b0, 0, 1'b0);
    for (int c = 0; c < 600; c++) begin
      bit add;
      bit ack;
      int a;
      int free_v[$];
      ack = ($urandom_range(0, 99) < 45);
      add = ($urandom_range(0, 99) < 45);
      for (int v = 0; v < D; v++) if (!in_pool(v)) free_v.push_back(v);
      if (free_v.size() != 0) a = free_v[$urandom_range(0, free_v.size() - 1)];
      else a = $urandom_range(0, D - 1);
      step(add, a, ack);
    end

    // Bring the pool to three entries, then reset mid-stream.
    for (int c = 0; c < 8 * D && m_q.size() != 3; c++) begin
      if (m_q.size() > 3) step(1'b0, 0, m_pres);
      else begin
        int a;
        a = 0;
        for (int v = D - 1; v >= 0; v--) if (!in_pool(v)) a = v;
        step(1'b1, a, 1'b0);
      end
    end
    check_val("pre_rst_cnt", 32'(empty_cnt), 3);
    do_reset("rst2");
    for (int c = 0; c < D + 1; c++) step(1'b0, 0, 1'b0);
    drain_in_order("reinit");
    check_outputs();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
